// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree with a frame accumulator and an output stage.
// Each beat of LENGTH elements is reduced by a registered binary tree. Tree
// results are accumulated until a beat tagged "last" closes the frame. The
// frame sum is then clamped or wrapped to Q_SIZE bits and presented with a
// valid/ready handshake. A single global enable freezes the entire pipeline
// while a finished result waits for the consumer.
module pipelined_adder_tree #(
    parameter int Q_SIZE   = 16,
    parameter int LENGTH   = 8,
    parameter int SATURATE = 1,
    parameter int ACC_EXT  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_last,
    input  logic [LENGTH-1:0][Q_SIZE-1:0]  x,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [Q_SIZE-1:0]              y,
    output logic                           out_ovf
);

    localparam int LEVELS = $clog2(LENGTH);
    localparam int ACC_W  = Q_SIZE + LEVELS + ACC_EXT;
    localparam int PADDED = 1 << LEVELS;

    typedef enum logic {
        IDLE,
        ACCUM
    } acc_state_t;

    // The pipeline moves only when the output register is empty or is being
    // drained this cycle. The same enable is offered upstream as in_ready.
    logic en;
    logic accept;

    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign accept   = in_valid && en;

    // Level 0 is the padded leaf row, driven straight from the input port.
    // Each later level is registered and holds half as many nodes as the
    // level before it. Each node is one bit wider than its children, so the
    // sums can never overflow inside the tree.
    genvar l, n;
    generate
        for (l = 0; l <= LEVELS; l++) begin : lvl
            localparam int NN = PADDED >> l;
            localparam int W  = Q_SIZE + l;

            logic signed [W-1:0] data [NN];
            logic                vld;
            logic                lst;

            if (l == 0) begin : g_leaf
                for (n = 0; n < NN; n++) begin : g_pad
                    if (n < LENGTH) begin : g_real
                        assign data[n] = x[n];
                    end else begin : g_zero
                        assign data[n] = '0;
                    end
                end
                assign vld = accept;
                assign lst = accept && in_last;
            end else begin : g_node
                // One registered reduction step. A bubble propagates when
                // no beat was accepted, because vld follows the level below.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        vld <= 1'b0;
                        lst <= 1'b0;
                        for (int i = 0; i < NN; i++) begin
                            data[i] <= '0;
                        end
                    end else if (en) begin
                        vld <= lvl[l-1].vld;
                        lst <= lvl[l-1].lst;
                        for (int i = 0; i < NN; i++) begin
                            data[i] <= W'(lvl[l-1].data[2*i]) + W'(lvl[l-1].data[2*i+1]);
                        end
                    end
                end
            end
        end
    endgenerate

    logic signed [ACC_W-1:0]     tree_ext;
    logic                        tree_vld;
    logic                        tree_lst;

    assign tree_ext = ACC_W'(lvl[LEVELS].data[0]);
    assign tree_vld = lvl[LEVELS].vld;
    assign tree_lst = lvl[LEVELS].lst;

    acc_state_t                  state;
    acc_state_t                  state_next;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     acc_next;
    logic signed [ACC_W-1:0]     sum;
    logic [LEVELS+ACC_EXT:0]     top_bits;
    logic                        sum_ovf;
    logic [Q_SIZE-1:0]           y_next;
    logic                        load_out;

    // Accumulator state register. Reset discards any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
        end else if (en) begin
            state <= state_next;
            acc   <= acc_next;
        end
    end

    // Frame sum, range check, output formatting and next accumulator state.
    // The value fits in Q_SIZE signed bits only when every bit from the
    // Q_SIZE sign position upward is identical.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        load_out   = 1'b0;

        sum      = ((state == ACCUM) ? acc : '0) + tree_ext;
        top_bits = sum[ACC_W-1:Q_SIZE-1];
        sum_ovf  = !((&top_bits) || !(|top_bits));

        y_next = sum[Q_SIZE-1:0];
        if ((SATURATE != 0) && sum_ovf) begin
            if (sum[ACC_W-1]) begin
                y_next = {1'b1, {(Q_SIZE-1){1'b0}}};
            end else begin
                y_next = {1'b0, {(Q_SIZE-1){1'b1}}};
            end
        end

        if (tree_vld) begin
            if (tree_lst) begin
                acc_next   = '0;
                state_next = IDLE;
                load_out   = 1'b1;
            end else begin
                acc_next   = sum;
                state_next = ACCUM;
            end
        end
    end

    // Output register. When en is high and out_valid is set, the consumer is
    // taking the result, so out_valid drops unless a new result arrives in
    // the same cycle. While stalled, y and out_ovf stay unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            out_ovf   <= 1'b0;
        end else if (en) begin
            if (load_out) begin
                out_valid <= 1'b1;
                y         <= y_next;
                out_ovf   <= sum_ovf;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench for pipelined_adder_tree. Three instances run in parallel:
// a saturating Q8xL4 instance, a wrapping Q8xL4 instance, and a Q8xL5 instance
// that exercises leaf padding.
module tb_pipelined_adder_tree;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_last;
    logic            out_ready;
    logic [3:0][7:0] x;
    logic [4:0][7:0] x5;

    logic            in_ready,   out_valid,   out_ovf;
    logic [7:0]      y;
    logic            w_in_ready, w_out_valid, w_out_ovf;
    logic [7:0]      w_y;
    logic            p_in_ready, p_out_valid, p_out_ovf;
    logic [7:0]      p_y;

    int checks   = 0;
    int failures = 0;

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    pipelined_adder_tree #(.Q_SIZE(8), .LENGTH(4), .SATURATE(1), .ACC_EXT(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .x(x), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .out_ovf(out_ovf)
    );

    pipelined_adder_tree #(.Q_SIZE(8), .LENGTH(4), .SATURATE(0), .ACC_EXT(8)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_last(in_last), .x(x), .out_valid(w_out_valid), .out_ready(out_ready),
        .y(w_y), .out_ovf(w_out_ovf)
    );

    pipelined_adder_tree #(.Q_SIZE(8), .LENGTH(5), .SATURATE(1), .ACC_EXT(8)) dut_pad (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(p_in_ready),
        .in_last(in_last), .x(x5), .out_valid(p_out_valid), .out_ready(out_ready),
        .y(p_y), .out_ovf(p_out_ovf)
    );

    // Counts one comparison and reports it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Presents one beat at a negedge and holds it until it is accepted, with
    // a bounded wait. Returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [7:0] a0, input logic [7:0] a1,
                                 input logic [7:0] a2, input logic [7:0] a3,
                                 input logic last);
        bit ok;
        ok = 1'b0;
        x[0] = a0; x[1] = a1; x[2] = a2; x[3] = a3;
        x5[0] = a0; x5[1] = a1; x5[2] = a2; x5[3] = a3;
        in_valid = 1'b1;
        in_last  = last;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            @(negedge clk);
        end
        if (!ok) checkOutput("accept_timeout", 32'(ok), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Waits up to maxw cycles for a result, checks it on both L4 instances,
    // and lets the handshake complete.
    task automatic expectResult(input string tag, input logic [7:0] ey, input logic eovf,
                                input logic [7:0] ewy, input int maxw);
        for (int i = 0; i < maxw && !out_valid; i++) @(negedge clk);
        checkOutput({tag, "_valid"},  32'(out_valid), 32'd1);
        checkOutput({tag, "_y"},      32'(y),         32'(ey));
        checkOutput({tag, "_ovf"},    32'(out_ovf),   32'(eovf));
        checkOutput({tag, "_wrap_y"}, 32'(w_y),       32'(ewy));
        checkOutput({tag, "_wrap_ovf"}, 32'(w_out_ovf), 32'(eovf));
        @(negedge clk);
    endtask

    // Stops the simulation if the stimulus never completes.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenario sequence.
    initial begin
        int spur;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        x = '0; x5 = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_valid",   32'(out_valid),   32'd0);
        checkOutput("rst_y",       32'(y),           32'd0);
        checkOutput("rst_ovf",     32'(out_ovf),     32'd0);
        checkOutput("rst_ready",   32'(in_ready),    32'd1);
        checkOutput("rst_w_valid", 32'(w_out_valid), 32'd0);
        checkOutput("rst_p_ready", 32'(p_in_ready),  32'd1);
        checkOutput("rst_w_ready", 32'(w_in_ready),  32'd1);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(in_ready), 32'd1);

        $display("[TB] single beat and padding latency");
        x5[4] = 8'd5;
        applyStimulus(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
        checkOutput("lat_c1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_c2_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_c3_valid", 32'(out_valid),   32'd1);
        checkOutput("single_y",     32'(y),           32'd10);
        checkOutput("single_ovf",   32'(out_ovf),     32'd0);
        checkOutput("single_w_y",   32'(w_y),         32'd10);
        checkOutput("pad_c3_valid", 32'(p_out_valid), 32'd0);
        @(negedge clk);
        checkOutput("single_once",  32'(out_valid),   32'd0);
        checkOutput("pad_c4_valid", 32'(p_out_valid), 32'd1);
        checkOutput("pad_y",        32'(p_y),         32'd15);
        checkOutput("pad_ovf",      32'(p_out_ovf),   32'd0);
        @(negedge clk);
        checkOutput("pad_once",     32'(p_out_valid), 32'd0);

        $display("[TB] saturation and wrap boundaries");
        applyStimulus(8'd100, 8'd100, 8'd100, 8'd100, 1'b1);
        expectResult("sat_pos", 8'h7f, 1'b1, 8'h90, 5);
        applyStimulus(8'h9c, 8'h9c, 8'h9c, 8'h9c, 1'b1);
        expectResult("sat_neg", 8'h80, 1'b1, 8'h70, 5);
        applyStimulus(8'd32, 8'd32, 8'd32, 8'd32, 1'b1);
        expectResult("edge_128", 8'h7f, 1'b1, 8'h80, 5);
        applyStimulus(8'he0, 8'he0, 8'he0, 8'he0, 1'b1);
        expectResult("edge_m128", 8'h80, 1'b0, 8'h80, 5);
        applyStimulus(8'd127, 8'd0, 8'd0, 8'd0, 1'b1);
        expectResult("edge_127", 8'h7f, 1'b0, 8'h7f, 5);

        $display("[TB] multi-beat frame and back-to-back frame");
        applyStimulus(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
        applyStimulus(8'd2, 8'd2, 8'd2, 8'd2, 1'b0);
        applyStimulus(8'hfd, 8'hfd, 8'hfd, 8'hfd, 1'b1);
        applyStimulus(8'd5, 8'd0, 8'd0, 8'd0, 1'b1);
        expectResult("frame3", 8'd0, 1'b0, 8'd0, 5);
        expectResult("frame_next", 8'd5, 1'b0, 8'd5, 0);
        checkOutput("frame_idle", 32'(out_valid), 32'd0);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(8'd1, 8'd0, 8'd0, 8'd0, 1'b1);
        applyStimulus(8'd2, 8'd0, 8'd0, 8'd0, 1'b0);
        applyStimulus(8'd0, 8'd3, 8'd0, 8'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_ready", 32'(in_ready),  32'd0);
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_y",     32'(y),         32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        expectResult("bp_a", 8'd1, 1'b0, 8'd1, 0);
        expectResult("bp_b", 8'd5, 1'b0, 8'd5, 2);
        checkOutput("bp_drain", 32'(out_valid), 32'd0);

        $display("[TB] mid-frame reset");
        applyStimulus(8'd1, 8'd1, 8'd1, 8'd1, 1'b0);
        applyStimulus(8'd2, 8'd2, 8'd2, 8'd2, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mrst_valid", 32'(out_valid), 32'd0);
        checkOutput("mrst_y",     32'(y),         32'd0);
        checkOutput("mrst_ovf",   32'(out_ovf),   32'd0);
        checkOutput("mrst_ready", 32'(in_ready),  32'd1);
        rst = 1'b0;
        spur = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) spur++;
        end
        checkOutput("mrst_no_result", 32'(spur), 32'd0);
        applyStimulus(8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
        expectResult("after_rst", 8'd4, 1'b0, 8'd4, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
